// File: rtl/niu32_mc_alu_if.sv
// Request/response bundle for the niu32 multi-cycle ALU.
// Operands go master->slave, status and result come back.
interface niu32_mc_alu_if #(
  parameter int WORD_SIZE = 32,
  parameter int OP_BITS   = 5
);
  logic                 start;
  logic [OP_BITS-1:0]   func;
  logic [WORD_SIZE-1:0] a_in;
  logic [WORD_SIZE-1:0] b_in;
  logic                 busy;
  logic                 done;
  logic [WORD_SIZE-1:0] result;
  logic                 div_by_zero;

  modport master (
    output start, func, a_in, b_in,
    input  busy, done, result, div_by_zero
  );

  modport slave (
    input  start, func, a_in, b_in,
    output busy, done, result, div_by_zero
  );
endinterface

// File: rtl/niu32_mc_alu.sv
// niu32 multi-cycle ALU: single-cycle logic/arith ops plus optional
// shift-add MLT and restoring DIV, enabled by NIU32_ALU_MULDIV_EN.
module niu32_mc_alu #(
  parameter int WORD_SIZE = 32,
  parameter int OP_BITS   = 5
) (
  input logic           clk,
  input logic           reset,
  niu32_mc_alu_if.slave bus
);

  localparam int W  = WORD_SIZE;
  localparam int SH = $clog2(WORD_SIZE);

  localparam logic [OP_BITS-1:0] OP_SUB = OP_BITS'(0);
  localparam logic [OP_BITS-1:0] OP_ADD = OP_BITS'(1);
  localparam logic [OP_BITS-1:0] OP_NOT = OP_BITS'(4);
  localparam logic [OP_BITS-1:0] OP_AND = OP_BITS'(5);
  localparam logic [OP_BITS-1:0] OP_OR  = OP_BITS'(6);
  localparam logic [OP_BITS-1:0] OP_XOR = OP_BITS'(7);
  localparam logic [OP_BITS-1:0] OP_SUL = OP_BITS'(8);
  localparam logic [OP_BITS-1:0] OP_SSL = OP_BITS'(9);
  localparam logic [OP_BITS-1:0] OP_SUR = OP_BITS'(10);
  localparam logic [OP_BITS-1:0] OP_SSR = OP_BITS'(11);
  localparam logic [OP_BITS-1:0] OP_EQ  = OP_BITS'(12);
  localparam logic [OP_BITS-1:0] OP_NEQ = OP_BITS'(13);
  localparam logic [OP_BITS-1:0] OP_LT  = OP_BITS'(14);
  localparam logic [OP_BITS-1:0] OP_LEQ = OP_BITS'(15);

`ifdef NIU32_ALU_MULDIV_EN
  localparam logic [OP_BITS-1:0] OP_MLT = OP_BITS'(2);
  localparam logic [OP_BITS-1:0] OP_DIV = OP_BITS'(3);
  localparam logic [SH-1:0] LAST = SH'(W - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_EXEC, S_MUL, S_DIV, S_FIX, S_DONE
  } state_e;
`else
  typedef enum logic [1:0] {
    S_IDLE, S_EXEC, S_DONE
  } state_e;
`endif

  state_e             state_q, state_d;
  logic [OP_BITS-1:0] func_q, func_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic [W-1:0]       result_q, result_d;
  logic [W-1:0]       alu_y;
  logic [SH-1:0]      sh;

`ifdef NIU32_ALU_MULDIV_EN
  logic               dbz_q, dbz_d;
  logic               neg_q, neg_d;
  logic [W-1:0]       acc_q, acc_d;
  logic [SH-1:0]      cnt_q, cnt_d;
  logic [W-1:0]       mul_sum;
  logic [W:0]         trial;
  logic               is_mlt, div_zero, div_go;

  assign is_mlt   = (func_q == OP_MLT);
  assign div_zero = (func_q == OP_DIV) && (b_q == '0);
  assign div_go   = (func_q == OP_DIV) && (b_q != '0);
`endif

  assign sh = b_q[SH-1:0];

  always_comb begin
    alu_y = '0;
    case (func_q)
      OP_SUB: alu_y = a_q - b_q;
      OP_ADD: alu_y = a_q + b_q;
      OP_NOT: alu_y = ~a_q;
      OP_AND: alu_y = a_q & b_q;
      OP_OR:  alu_y = a_q | b_q;
      OP_XOR: alu_y = a_q ^ b_q;
      OP_SUL: alu_y = a_q << sh;
      OP_SSL: alu_y = a_q << sh;
      OP_SUR: alu_y = a_q >> sh;
      OP_SSR: alu_y = W'($signed(a_q) >>> sh);
      OP_EQ:  alu_y = W'(a_q == b_q);
      OP_NEQ: alu_y = W'(a_q != b_q);
      OP_LT:  alu_y = W'($signed(a_q) < $signed(b_q));
      OP_LEQ: alu_y = W'($signed(a_q) <= $signed(b_q));
      default: alu_y = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    func_d   = func_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
`ifdef NIU32_ALU_MULDIV_EN
    dbz_d    = dbz_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    mul_sum  = acc_q + (b_q[0] ? a_q : '0);
    trial    = {acc_q, a_q[W-1]} - {1'b0, b_q};
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          func_d  = bus.func;
          a_d     = bus.a_in;
          b_d     = bus.b_in;
          state_d = S_EXEC;
`ifdef NIU32_ALU_MULDIV_EN
          dbz_d   = 1'b0;
          neg_d   = 1'b0;
          acc_d   = '0;
          cnt_d   = '0;
`endif
        end
      end
      S_EXEC: begin
`ifdef NIU32_ALU_MULDIV_EN
        // Divide works on magnitudes; the sign is restored in FIX.
        unique case (1'b1)
          is_mlt: state_d = S_MUL;
          div_zero: begin
            result_d = '1;
            dbz_d    = 1'b1;
            state_d  = S_DONE;
          end
          div_go: begin
            a_d     = a_q[W-1] ? -a_q : a_q;
            b_d     = b_q[W-1] ? -b_q : b_q;
            neg_d   = a_q[W-1] ^ b_q[W-1];
            state_d = S_DIV;
          end
          default: begin
            result_d = alu_y;
            state_d  = S_DONE;
          end
        endcase
`else
        result_d = alu_y;
        state_d  = S_DONE;
`endif
      end
`ifdef NIU32_ALU_MULDIV_EN
      S_MUL: begin
        acc_d = mul_sum;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          result_d = mul_sum;
          state_d  = S_DONE;
        end
      end
      S_DIV: begin
        acc_d = trial[W] ? {acc_q[W-2:0], a_q[W-1]}
                         : trial[W-1:0];
        a_d   = {a_q[W-2:0], ~trial[W]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = S_FIX;
      end
      S_FIX: begin
        result_d = neg_q ? -a_q : a_q;
        state_d  = S_DONE;
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      func_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
`ifdef NIU32_ALU_MULDIV_EN
      dbz_q    <= 1'b0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      func_q   <= func_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
`ifdef NIU32_ALU_MULDIV_EN
      dbz_q    <= dbz_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign bus.busy   = (state_q != S_IDLE);
  assign bus.done   = (state_q == S_DONE);
  assign bus.result = result_q;
`ifdef NIU32_ALU_MULDIV_EN
  assign bus.div_by_zero = dbz_q;
`else
  assign bus.div_by_zero = 1'b0;
`endif

endmodule
